// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core sequencer: opcodes, instruction
// field positions, sequencer state encoding and ALU function selects.
package cpu_pkg;

  // Opcode values carried in instruction bits [18:15]
  localparam logic [3:0] OP_ALU0 = 4'b0000;
  localparam logic [3:0] OP_ALU1 = 4'b0001;
  localparam logic [3:0] OP_ALU2 = 4'b0010;
  localparam logic [3:0] OP_ALU3 = 4'b0011;
  localparam logic [3:0] OP_MOV  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b0110;

  // Instruction field bit positions
  localparam int OPC_HI  = 18;
  localparam int OPC_LO  = 15;
  localparam int FS_HI   = 16;
  localparam int FS_LO   = 15;
  localparam int DST_HI  = 14;
  localparam int DST_LO  = 10;
  localparam int SRCA_HI = 9;
  localparam int SRCA_LO = 5;
  localparam int SRCB_HI = 4;
  localparam int SRCB_LO = 0;

  // ALU function selects (low two opcode bits of an ALU instruction)
  localparam logic [1:0] ALU_FS0 = 2'd0;
  localparam logic [1:0] ALU_FS1 = 2'd1;
  localparam logic [1:0] ALU_FS2 = 2'd2;
  localparam logic [1:0] ALU_FS3 = 2'd3;

  // Sequencer states; IDLE must stay at code zero
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_READA  = 3'd3,
    ST_READB  = 3'd4,
    ST_EXEC   = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } seq_state_e;

  // Program counter advance; wraps 31 -> 0 through 5-bit truncation
  function automatic logic [4:0] pc_inc(input logic [4:0] pc_val);
    return pc_val + 5'd1;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Opcode classifier for the sequencer: one-hot instruction class flags.
module seq_decode
  import cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic       o_is_alu,
  output logic       o_is_mov,
  output logic       o_is_jmp,
  output logic       o_is_halt,
  output logic       o_is_illegal
);

  // Classify the opcode; everything outside the defined set is illegal
  always_comb begin
    o_is_alu     = 1'b0;
    o_is_mov     = 1'b0;
    o_is_jmp     = 1'b0;
    o_is_halt    = 1'b0;
    o_is_illegal = 1'b0;
    case (i_opcode)
      OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3: o_is_alu  = 1'b1;
      OP_MOV:                             o_is_mov  = 1'b1;
      OP_JMP:                             o_is_jmp  = 1'b1;
      OP_HALT:                            o_is_halt = 1'b1;
      default:                            o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute sequencer: drives instruction ROM, register file and
// ALU operand latches, and owns PC, flags, halt and illegal-opcode state.
module exec_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_rd,
  output logic [4:0]  imem_addr,
  input  logic [18:0] imem_data,
  output logic        rf_rd,
  output logic [4:0]  rf_rsel,
  input  logic [7:0]  rf_rdata,
  output logic        rf_wr,
  output logic [4:0]  rf_wsel,
  output logic [7:0]  rf_wdata,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_fs,
  input  logic [7:0]  alu_y,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  flags,
  output logic [4:0]  pc,
  output logic        halted,
  output logic        illegal
);

  seq_state_e  r_state;
  seq_state_e  w_state_nxt;
  logic [4:0]  r_pc;
  logic [4:0]  w_pc_nxt;
  logic [18:0] r_ir;
  logic [18:0] w_ir_nxt;
  logic [7:0]  r_opa;
  logic [7:0]  w_opa_nxt;
  logic [7:0]  r_opb;
  logic [7:0]  w_opb_nxt;
  logic [3:0]  r_flags;
  logic [3:0]  w_flags_nxt;
  logic        r_illegal;
  logic        w_illegal_nxt;

  logic [3:0]  w_opcode;
  logic        w_is_alu;
  logic        w_is_mov;
  logic        w_is_jmp;
  logic        w_is_halt;
  logic        w_is_illegal;

  // In DECODE the word is still on the ROM bus; later states use the latched copy
  assign w_opcode = (r_state == ST_DECODE) ? imem_data[OPC_HI:OPC_LO] : r_ir[OPC_HI:OPC_LO];

  seq_decode u_decode (
    .i_opcode     (w_opcode),
    .o_is_alu     (w_is_alu),
    .o_is_mov     (w_is_mov),
    .o_is_jmp     (w_is_jmp),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign flags     = r_flags;
  assign illegal   = r_illegal;
  assign alu_a     = r_opa;
  assign alu_b     = r_opb;
  assign alu_fs    = r_ir[FS_HI:FS_LO];
  assign halted    = (r_state == ST_HALT);

  // State, PC, instruction and operand registers; reset aborts any instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= 5'd0;
      r_ir      <= 19'd0;
      r_opa     <= 8'd0;
      r_opb     <= 8'd0;
      r_flags   <= 4'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_opa     <= w_opa_nxt;
      r_opb     <= w_opb_nxt;
      r_flags   <= w_flags_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  // Next-state, datapath updates and per-state strobes (one strobe at most)
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_opa_nxt     = r_opa;
    w_opb_nxt     = r_opb;
    w_flags_nxt   = r_flags;
    w_illegal_nxt = r_illegal;
    imem_rd       = 1'b0;
    rf_rd         = 1'b0;
    rf_rsel       = 5'd0;
    rf_wr         = 1'b0;
    rf_wsel       = 5'd0;
    rf_wdata      = 8'd0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        imem_rd     = 1'b1;
        w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        w_ir_nxt = imem_data;
        if (w_is_alu || w_is_mov) begin
          w_state_nxt = ST_READA;
        end else if (w_is_jmp) begin
          w_pc_nxt    = imem_data[SRCB_HI:SRCB_LO];
          w_state_nxt = ST_FETCH;
        end else if (w_is_halt) begin
          w_state_nxt = ST_HALT;
        end else if (w_is_illegal) begin
          w_illegal_nxt = 1'b1;
          w_pc_nxt      = pc_inc(r_pc);
          w_state_nxt   = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READA: begin
        rf_rd       = 1'b1;
        rf_rsel     = r_ir[SRCA_HI:SRCA_LO];
        w_state_nxt = ST_READB;
      end
      ST_READB: begin
        w_opa_nxt = rf_rdata;
        if (w_is_alu) begin
          rf_rd       = 1'b1;
          rf_rsel     = r_ir[SRCB_HI:SRCB_LO];
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      ST_EXEC: begin
        w_opb_nxt   = rf_rdata;
        w_state_nxt = ST_WB;
      end
      ST_WB: begin
        rf_wr   = 1'b1;
        rf_wsel = r_ir[DST_HI:DST_LO];
        if (w_is_alu) begin
          rf_wdata    = alu_y;
          w_flags_nxt = alu_flags;
        end else begin
          rf_wdata = r_opa;
        end
        w_pc_nxt    = pc_inc(r_pc);
        w_state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: ROM, register file and ALU models
// around the DUT, with an instruction-level reference interpreter.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_rd;
  logic [4:0]  imem_addr;
  logic [18:0] imem_data = 19'd0;
  logic        rf_rd;
  logic [4:0]  rf_rsel;
  logic [7:0]  rf_rdata = 8'd0;
  logic        rf_wr;
  logic [4:0]  rf_wsel;
  logic [7:0]  rf_wdata;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [1:0]  alu_fs;
  logic [7:0]  alu_y;
  logic [3:0]  alu_flags;
  logic [3:0]  flags;
  logic [4:0]  pc;
  logic        halted;
  logic        illegal;

  logic [18:0] rom    [32];
  logic [7:0]  env_rf [32];
  logic        preload = 1'b0;

  // Reference machine state
  logic [7:0]  m_regs [32];
  logic [4:0]  m_pc;
  logic [3:0]  m_flags;
  logic        m_illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .rf_rd(rf_rd), .rf_rsel(rf_rsel), .rf_rdata(rf_rdata),
    .rf_wr(rf_wr), .rf_wsel(rf_wsel), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fs(alu_fs),
    .alu_y(alu_y), .alu_flags(alu_flags),
    .flags(flags), .pc(pc), .halted(halted), .illegal(illegal)
  );

  // ALU behaviour: {flags, y}; flags = {carry, sign, zero, parity}
  function automatic logic [11:0] alu_ref(input logic [1:0] fs, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    case (fs)
      2'd0:    r = {1'b0, a} + {1'b0, b};
      2'd1:    r = {1'b0, a} - {1'b0, b};
      2'd2:    r = {1'b0, a & b};
      default: r = {1'b0, a ^ b};
    endcase
    return {r[8], r[7], (r[7:0] == 8'd0), ^r[7:0], r[7:0]};
  endfunction

  assign {alu_flags, alu_y} = alu_ref(alu_fs, alu_a, alu_b);

  // ROM model: data valid the cycle after the fetch strobe
  always @(posedge clk) if (imem_rd) imem_data <= rom[imem_addr];

  // Register file model: registered read, write at end of cycle
  always @(posedge clk) begin
    if (rf_rd) rf_rdata <= env_rf[rf_rsel];
    if (preload) begin
      for (int i = 0; i < 32; i++) env_rf[i] <= m_regs[i];
    end else if (rf_wr) begin
      env_rf[rf_wsel] <= rf_wdata;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge where the DUT should be fetching; runs one instruction
  task automatic run_instr();
    logic [18:0] ins;
    logic [3:0]  opc;
    logic [4:0]  dst, sa, sb;
    logic [11:0] res;
    int          lat, n_exp_rd, n_rd, n_wr, cyc;
    logic [4:0]  exp_rs [2];
    logic [4:0]  obs_rs [2];
    logic        exp_wr;
    logic [7:0]  exp_wd, obs_wd;
    logic [4:0]  obs_ws;
    ins = rom[m_pc];
    opc = ins[18:15]; dst = ins[14:10]; sa = ins[9:5]; sb = ins[4:0];
    exp_wr = 1'b0; exp_wd = 8'd0; n_exp_rd = 0;
    exp_rs[0] = sa; exp_rs[1] = sb;
    obs_rs[0] = 5'd0; obs_rs[1] = 5'd0; obs_ws = 5'd0; obs_wd = 8'd0;
    check_val("fetch_rd", {31'd0, imem_rd}, 32'd1);
    check_val("fetch_addr", {27'd0, imem_addr}, {27'd0, m_pc});
    if (opc <= 4'd3) begin
      lat = 6; n_exp_rd = 2; exp_wr = 1'b1;
      res = alu_ref(opc[1:0], m_regs[sa], m_regs[sb]);
      exp_wd = res[7:0];
    end else if (opc == 4'd4) begin
      lat = 5; n_exp_rd = 1; exp_wr = 1'b1;
      exp_wd = m_regs[sa];
    end else begin
      lat = 2;
    end
    n_rd = 0; n_wr = 0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      check_val("strobe_excl", {31'd0, ($countones({imem_rd, rf_rd, rf_wr}) > 1)}, 32'd0);
      if (rf_rd) begin
        if (n_rd < 2) obs_rs[n_rd] = rf_rsel;
        n_rd++;
      end
      if (rf_wr) begin
        obs_ws = rf_wsel; obs_wd = rf_wdata; n_wr++;
      end
    end while (!imem_rd && cyc < 16);
    // Update reference state from the ISA rules
    if (opc <= 4'd3) begin
      m_flags = res[11:8]; m_regs[dst] = exp_wd; m_pc = m_pc + 5'd1;
    end else if (opc == 4'd4) begin
      m_regs[dst] = exp_wd; m_pc = m_pc + 5'd1;
    end else if (opc == 4'd5) begin
      m_pc = sb;
    end else begin
      m_illegal = 1'b1; m_pc = m_pc + 5'd1;
    end
    check_val("latency", cyc, lat);
    check_val("rd_count", n_rd, n_exp_rd);
    for (int k = 0; k < 2; k++) begin
      if (k < n_exp_rd) check_val("rd_sel", {27'd0, obs_rs[k]}, {27'd0, exp_rs[k]});
    end
    check_val("wr_count", n_wr, exp_wr ? 1 : 0);
    if (exp_wr) begin
      check_val("wr_sel", {27'd0, obs_ws}, {27'd0, dst});
      check_val("wr_data", {24'd0, obs_wd}, {24'd0, exp_wd});
    end
    check_val("pc", {27'd0, pc}, {27'd0, m_pc});
    check_val("flags", {28'd0, flags}, {28'd0, m_flags});
    check_val("illegal", {31'd0, illegal}, {31'd0, m_illegal});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_strobes"}, {29'd0, imem_rd, rf_rd, rf_wr}, 32'd0);
    check_val({tag, "_pc"}, {27'd0, pc}, 32'd0);
    check_val({tag, "_addr"}, {27'd0, imem_addr}, 32'd0);
    check_val({tag, "_flags"}, {28'd0, flags}, 32'd0);
    check_val({tag, "_hlt_ill"}, {30'd0, halted, illegal}, 32'd0);
    check_val({tag, "_sels"}, {17'd0, rf_rsel, rf_wsel, rf_wdata}, 32'd0);
    check_val({tag, "_alu"}, {14'd0, alu_fs, alu_a, alu_b}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    m_pc = 5'd0; m_flags = 4'd0; m_illegal = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] rv;
    logic [3:0]  op;
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rv = $urandom; m_regs[i] = rv[7:0]; rom[i] = 19'd0;
    end
    m_regs[1] = 8'h55; m_regs[3] = 8'hAB; m_regs[15] = 8'h3C;
    rom[0]  = {4'd0, 5'd2, 5'd1, 5'd3};    // ALU fs0: R2 = R1 op R3
    rom[1]  = {4'd4, 5'd30, 5'd15, 5'd0};  // MOV R30 = R15
    rom[2]  = {4'd5, 5'd0, 5'd0, 5'd31};   // JMP 31
    rom[3]  = {4'd6, 15'd0};               // HALT
    rom[31] = {4'd4, 5'd4, 5'd2, 5'd0};    // MOV R4 = R2
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    do_reset();
    check_reset_outputs("reset");
    @(negedge clk);
    check_val("idle_no_start", {31'd0, imem_rd}, 32'd0);
    do_start();

    // Directed program: ALU, MOV, JMP 31, MOV wrapping to 0
    run_instr();
    run_instr();
    run_instr();
    rv = $urandom;
    rom[2] = {4'b1010, rv[14:0]};
    run_instr();
    check_val("pc_wrap", {27'd0, pc}, 32'd0);
    run_instr();
    run_instr();
    run_instr();  // illegal at pc 2

    // HALT at pc 3: quiet for 20 cycles, start ignored
    check_val("halt_fetch", {27'd0, imem_addr}, 32'd3);
    repeat (2) @(negedge clk);
    check_val("halted", {31'd0, halted}, 32'd1);
    for (int c = 0; c < 20; c++) begin
      rv = $urandom;
      start = rv[0];
      @(negedge clk);
      check_val("halt_quiet", {28'd0, imem_rd, rf_rd, rf_wr, halted}, 32'd1);
      check_val("halt_pc", {27'd0, pc}, 32'd3);
    end
    start = 1'b0;

    // Reset during EXEC of an ALU op aborts the write and flag update
    rom[0] = {4'd0, 5'd5, 5'd1, 5'd3};
    rom[1] = {4'd1, 5'd6, 5'd1, 5'd3};
    do_reset();
    do_start();
    run_instr();
    check_val("flags_set", {31'd0, (flags != 4'd0)}, 32'd1);
    repeat (4) @(negedge clk);
    check_val("in_exec", {29'd0, imem_rd, rf_rd, rf_wr}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pc = 5'd0; m_flags = 4'd0; m_illegal = 1'b0;
    check_reset_outputs("abort");
    repeat (3) begin
      @(negedge clk);
      check_val("abort_idle", {29'd0, imem_rd, rf_rd, rf_wr}, 32'd0);
    end
    check_val("abort_nowrite", {24'd0, env_rf[6]}, {24'd0, m_regs[6]});

    // Random 100-instruction program (no HALT)
    for (int i = 0; i < 32; i++) begin
      rv = $urandom;
      op = rv[18:15];
      if (op == 4'd6) op = 4'd4;
      rom[i] = {op, rv[14:0]};
    end
    do_reset();
    do_start();
    for (int i = 0; i < 100; i++) run_instr();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
